add12u_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one external 12-bit unsigned adder (13-bit result) between NREQ requesters.
- The adder is combinational and sits outside this block, connected via add_a/add_b/add_o, so exact and approximate add12u variants are interchangeable without RTL change.
- A one-entry registered result stage gives valid/ready handshakes on both sides.
- Used wherever several datapath lanes need occasional additions but only one adder instance fits the area/power budget.

---
 rtl/add12u_share_arb.sv | 152 +++++++++++++++
 tb/tb_add12u_share_arb.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/add12u_share_arb.sv
// add12u_share_arb: round-robin arbiter and sequencer sharing one external
// combinational 12-bit unsigned adder (13-bit sum) between NREQ requesters.
// The result is captured in a single-entry register with valid/ready handshakes.
// Optional error monitor: define ADD12U_ARB_ERRMON_EN to add err_cnt/err_max.
module add12u_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [12*NREQ-1:0]   req_a,
  input  logic [12*NREQ-1:0]   req_b,
  output logic [11:0]          add_a,
  output logic [11:0]          add_b,
  input  logic [12:0]          add_o,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [12:0]          res_sum,
  output logic [IDW-1:0]       res_id
`ifdef ADD12U_ARB_ERRMON_EN
  ,
  output logic [15:0]          err_cnt,
  output logic [12:0]          err_max
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_reg, state_next;
  logic [12:0]    sum_reg, sum_next;
  logic [IDW-1:0] id_reg, id_next;
  logic [IDW-1:0] ptr_reg, ptr_next;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic           can_accept;
  logic           xfer;

  logic [11:0]    a_arr [NREQ];
  logic [11:0]    b_arr [NREQ];

  // Unpack the flat operand buses into per-requester lanes.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[12*gi +: 12];
    assign b_arr[gi] = req_b[12*gi +: 12];
  end

  // Round-robin scan starting at the pointer; first valid requester wins.
  always_comb begin
    int             idx;
    logic [NREQ-1:0] rv_shift;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    rv_shift    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      rv_shift = req_valid >> idx;
      if (!grant_found && rv_shift[0]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  // Drive the shared adder from the granted lane even while stalled, so its
  // output stays stable; idle bus is zero.
  always_comb begin
    add_a = 12'd0;
    add_b = 12'd0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_found && grant_idx == IDW'(j)) begin
        add_a = a_arr[j];
        add_b = b_arr[j];
      end
    end
  end

  // The result slot can take a new sum when empty or when it is being drained
  // this same cycle; nothing is granted while reset is asserted.
  assign can_accept = (state_reg == EMPTY) || res_ready;
  assign xfer       = grant_found && can_accept && !rst;
  assign req_ready  = xfer ? (NREQ'(1) << grant_idx) : '0;

  // Next-state logic: capture on transfer, otherwise drain or hold.
  always_comb begin
    state_next = state_reg;
    sum_next   = sum_reg;
    id_next    = id_reg;
    ptr_next   = ptr_reg;
    if (xfer) begin
      state_next = FULL;
      sum_next   = add_o;
      id_next    = grant_idx;
      ptr_next   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end else if (state_reg == FULL && res_ready) begin
      state_next = EMPTY;
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      sum_reg   <= 13'd0;
      id_reg    <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sum_reg   <= sum_next;
      id_reg    <= id_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign res_valid = (state_reg == FULL);
  assign res_sum   = sum_reg;
  assign res_id    = id_reg;

`ifdef ADD12U_ARB_ERRMON_EN
  logic [12:0] ref_sum;
  logic [12:0] err_abs;
  logic [15:0] err_cnt_reg;
  logic [12:0] err_max_reg;

  // Exact reference sum and absolute deviation of the external adder.
  always_comb begin
    ref_sum = {1'b0, add_a} + {1'b0, add_b};
    err_abs = (add_o >= ref_sum) ? (add_o - ref_sum) : (ref_sum - add_o);
  end

  // Count erroneous transfers (saturating) and track the worst deviation.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= 16'd0;
      err_max_reg <= 13'd0;
    end else if (xfer) begin
      if (add_o != ref_sum && err_cnt_reg != 16'hFFFF)
        err_cnt_reg <= err_cnt_reg + 16'd1;
      if (err_abs > err_max_reg)
        err_max_reg <= err_abs;
    end
  end

  assign err_cnt = err_cnt_reg;
  assign err_max = err_max_reg;
`endif

endmodule

// File: tb/tb_add12u_share_arb.sv
// Directed testbench for add12u_share_arb with an exact adder model
// (optionally with its LSB forced to zero to exercise the error monitor).
module tb_add12u_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [12*NREQ-1:0] req_a;
  logic [12*NREQ-1:0] req_b;
  logic [11:0]       add_a;
  logic [11:0]       add_b;
  logic [12:0]       add_o;
  logic              res_valid;
  logic              res_ready;
  logic [12:0]       res_sum;
  logic [IDW-1:0]    res_id;
  logic              force_lsb0;
`ifdef ADD12U_ARB_ERRMON_EN
  logic [15:0]       err_cnt;
  logic [12:0]       err_max;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  add12u_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_o     (add_o),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id)
`ifdef ADD12U_ARB_ERRMON_EN
    ,
    .err_cnt   (err_cnt),
    .err_max   (err_max)
`endif
  );

  always #5 clk = ~clk;

  // Shared adder model: exact, or with bit 0 forced low.
  logic [12:0] exact_sum;
  assign exact_sum = {1'b0, add_a} + {1'b0, add_b};
  assign add_o     = force_lsb0 ? (exact_sum & 13'h1FFE) : exact_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
    req_a[12*i +: 12] = a;
    req_b[12*i +: 12] = b;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    res_ready  = 1'b1;
    force_lsb0 = 1'b0;

    // Reset: outputs at reset values, no grant even with a request pending.
    set_op(0, 12'h0FF, 12'h001);
    req_valid = 4'b0001;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_valid", res_valid, 0);
    check("rst_sum",   res_sum,   0);
    check("rst_id",    res_id,    0);

    // Single request on lane 0.
    rst = 1'b0;
    #1;
    check("single_ready", req_ready, 4'b0001);
    check("single_add_a", add_a, 12'h0FF);
    check("single_add_b", add_b, 12'h001);
    @(negedge clk);
    check("single_valid", res_valid, 1);
    check("single_sum",   res_sum,   13'h100);
    check("single_id",    res_id,    0);

    // Carry-out kept: lane 2 0xFFF+0xFFF (pointer is at 1, scan reaches 2).
    req_valid = 4'b0100;
    set_op(2, 12'hFFF, 12'hFFF);
    #1;
    check("ovf_ready", req_ready, 4'b0100);
    @(negedge clk);
    check("ovf_sum", res_sum, 13'h1FFE);
    check("ovf_id",  res_id,  2);

    // No requests: adder bus idles at zero, result drains but sum holds.
    req_valid = '0;
    #1;
    check("idle_add_a",  add_a, 0);
    check("idle_ready",  req_ready, 0);
    @(negedge clk);
    check("drain_valid", res_valid, 0);
    check("drain_sum",   res_sum, 13'h1FFE);

    // Fairness: all lanes requesting, pointer reset to 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 12'(12'h100 * (i + 1)), 12'(i));
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("rr_ready%0d", c), req_ready, 32'(1) << (c % 4));
      if (c > 0) begin
        check($sformatf("rr_id%0d", c - 1),  res_id, (c - 1) % 4);
        check($sformatf("rr_sum%0d", c - 1), res_sum, 32'h100 * (((c - 1) % 4) + 1) + ((c - 1) % 4));
      end
      @(negedge clk);
    end
    check("rr_id4",  res_id,  0);
    check("rr_sum4", res_sum, 13'h100);

    // Backpressure: result held, lane 1 pending, nothing accepted for 5 cycles.
    req_valid = 4'b0010;
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp_ready%0d", c), req_ready, 0);
      check($sformatf("bp_sum%0d", c),   res_sum, 13'h100);
      check($sformatf("bp_valid%0d", c), res_valid, 1);
      check($sformatf("bp_add_a%0d", c), add_a, 12'h200);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 4'b0010);
    @(negedge clk);
    check("bp_release_sum",   res_sum, 13'h201);
    check("bp_release_id",    res_id,  1);
    check("bp_release_valid", res_valid, 1);

    // Reset during a stall: result discarded, priority back to lane 0.
    res_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("stall_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_stall_ready", req_ready, 0);
    @(negedge clk);
    check("rst_stall_valid", res_valid, 0);
    check("rst_stall_sum",   res_sum, 0);
    check("rst_stall_id",    res_id, 0);
    rst       = 1'b0;
    res_ready = 1'b1;
    #1;
    check("post_rst_ready", req_ready, 4'b0001);
    @(negedge clk);
    check("post_rst_id",  res_id, 0);
    check("post_rst_sum", res_sum, 13'h100);
    req_valid = '0;

`ifdef ADD12U_ARB_ERRMON_EN
    // Error monitor with a faulty adder (bit 0 stuck at zero): 1+2 gives 2.
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    force_lsb0 = 1'b1;
    set_op(0, 12'h001, 12'h002);
    req_valid = 4'b0001;
    #1;
    check("em_cnt0", err_cnt, 0);
    @(negedge clk);
    check("em_cnt1", err_cnt, 1);
    check("em_max1", err_max, 1);
    check("em_sum",  res_sum, 2);
    repeat (65540) @(negedge clk);
    check("em_cnt_sat", err_cnt, 16'hFFFF);
    check("em_max_sat", err_max, 1);
    req_valid  = '0;
    force_lsb0 = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
